// File: rtl/frb_playback_seq.sv
// BRAM-to-DAC playback sequencer: steps a programmed frame, repeats with idle gaps,
// and emits default_val when not playing. Optional external trigger via PLAYBACK_EXT_TRIG_EN.
module frb_playback_seq #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REP_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic [REP_WIDTH-1:0]  n_repeats,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic [DATA_WIDTH-1:0] default_val,
`ifdef PLAYBACK_EXT_TRIG_EN
  input  logic                  trig,
`endif
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] dac_val,
  output logic                  busy,
  output logic                  finish,
  output logic [REP_WIDTH-1:0]  rep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DRAIN,
    S_DONE
`ifdef PLAYBACK_EXT_TRIG_EN
    , S_ARM
`endif
  } state_t;

  // Every entry into PLAY is routed through ARM when the trigger is enabled.
`ifdef PLAYBACK_EXT_TRIG_EN
  localparam state_t PLAY_ENTRY = S_ARM;
`else
  localparam state_t PLAY_ENTRY = S_PLAY;
`endif

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [REP_WIDTH-1:0]  rep_d;
  logic [GAP_WIDTH-1:0]  gap_cnt, gap_d;
  logic                  drain_cnt, drain_d;
  logic                  load_cfg;
  logic [ADDR_WIDTH:0]   flen_q;
  logic [REP_WIDTH-1:0]  nrep_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic                  rd_v1;

`ifdef PLAYBACK_EXT_TRIG_EN
  logic trig_s1, trig_s2, trig_s3;
  logic trig_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_s3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bram_addr <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      drain_cnt <= 1'b0;
      flen_q    <= '0;
      nrep_q    <= '0;
      gap_q     <= '0;
    end else begin
      state     <= state_d;
      bram_addr <= addr_d;
      rep_cnt   <= rep_d;
      gap_cnt   <= gap_d;
      drain_cnt <= drain_d;
      if (load_cfg) begin
        flen_q <= frame_len;
        nrep_q <= n_repeats;
        gap_q  <= gap_cycles;
      end
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = bram_addr;
    rep_d    = rep_cnt;
    gap_d    = gap_cnt;
    drain_d  = drain_cnt;
    load_cfg = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load_cfg = 1'b1;
          rep_d    = '0;
          addr_d   = '0;
          state_d  = (frame_len == '0) ? S_DONE : PLAY_ENTRY;
        end
      end
      S_PLAY: begin
        if ({1'b0, bram_addr} == flen_q - 1'b1) begin
          addr_d = '0;
          if (rep_cnt != '1) rep_d = rep_cnt + 1'b1;
          if (nrep_q != '0 && rep_cnt == nrep_q - 1'b1) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else if (gap_q == '0) begin
            state_d = PLAY_ENTRY;
          end else begin
            state_d = S_GAP;
            gap_d   = gap_q - 1'b1;
          end
        end else begin
          addr_d = bram_addr + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_d = PLAY_ENTRY;
          addr_d  = '0;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt) state_d = S_DONE;
        else           drain_d = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
`ifdef PLAYBACK_EXT_TRIG_EN
      S_ARM: begin
        if (trig_rise) begin
          state_d = S_PLAY;
          addr_d  = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // DONE already leads to IDLE, so a late abort must not re-pulse finish.
    if (abort && state != S_IDLE && state != S_DONE) state_d = S_DONE;
  end

  always_comb begin
    bram_en = (state == S_PLAY);
    busy    = (state != S_IDLE);
    finish  = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1   <= 1'b0;
      dac_val <= '0;
    end else begin
      rd_v1   <= bram_en;
      dac_val <= rd_v1 ? bram_dout : default_val;
    end
  end

endmodule

// File: tb/tb_frb_playback_seq.sv
// Scoreboard bench for frb_playback_seq: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_frb_playback_seq;

  localparam logic [31:0] D = 32'h0000_AAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, trig;
  logic [11:0] frame_len;
  logic [15:0] n_repeats;
  logic [31:0] gap_cycles;
  logic [31:0] default_val;
  logic [10:0] bram_addr;
  logic        bram_en;
  logic [31:0] bram_dout;
  logic [31:0] dac_val;
  logic        busy, finish;
  logic [15:0] rep_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        en;
    logic [10:0] addr;
    logic [31:0] dac;
    logic        busy;
    logic        fin;
    logic [15:0] rep;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mx;
  string tname = "none";
  int    cyc_idx = 0;

  always #5 clk = ~clk;

  frb_playback_seq #(
    .ADDR_WIDTH(11),
    .DATA_WIDTH(32),
    .REP_WIDTH (16),
    .GAP_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .frame_len  (frame_len),
    .n_repeats  (n_repeats),
    .gap_cycles (gap_cycles),
    .default_val(default_val),
`ifdef PLAYBACK_EXT_TRIG_EN
    .trig       (trig),
`endif
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_dout  (bram_dout),
    .dac_val    (dac_val),
    .busy       (busy),
    .finish     (finish),
    .rep_cnt    (rep_cnt)
  );

  // BRAM contents: mem[k] = k + 100, one-cycle read latency.
  always @(posedge clk) bram_dout <= 32'(bram_addr) + 32'd100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() != 0) begin
        mx = exp_q.pop_front();
        chk($sformatf("%s_c%0d{en,addr,dac,busy,fin,rep}", tname, cyc_idx),
            {2'b00, bram_en, bram_en ? bram_addr : 11'd0, dac_val, busy, finish, rep_cnt},
            {2'b00, mx.en, mx.en ? mx.addr : 11'd0, mx.dac, mx.busy, mx.fin, mx.rep});
        cyc_idx++;
      end else begin
        chk("stray_finish", {63'd0, finish}, 64'd0);
      end
    end
  end

  task automatic e(input logic en, input int a, input logic [31:0] d,
                   input logic b, input logic f, input int r);
    exp_t x;
    x.en = en; x.addr = a[10:0]; x.dac = d; x.busy = b; x.fin = f; x.rep = r[15:0];
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test(input string n, input int fl, input int nr, input int g);
    tname      = n;
    cyc_idx    = 0;
    frame_len  = fl[11:0];
    n_repeats  = nr[15:0];
    gap_cycles = g;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({tname, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; trig = 1'b0;
    frame_len = '0; n_repeats = '0; gap_cycles = '0; default_val = D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  64'(bram_addr), 64'd0);
    chk("rst_en",    64'(bram_en),   64'd0);
    chk("rst_dac",   64'(dac_val),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_fin",   64'(finish),    64'd0);
    chk("rst_rep",   64'(rep_cnt),   64'd0);
    rst_n = 1'b1;
    tick();
    chk("first_clk_dac", 64'(dac_val), 64'(D));

    // Basic single frame
    begin_test("basic", 4, 1, 0);
    e(0,0,D,0,0,0); e(1,0,D,1,0,0); e(1,1,D,1,0,0); e(1,2,100,1,0,0); e(1,3,101,1,0,0);
    e(0,0,102,1,0,1); e(0,0,103,1,0,1); e(0,0,D,1,1,1); e(0,0,D,0,0,1);
    start = 1'b1; tick(); start = 1'b0;
    drain();

    // Two frames with a two-cycle gap
    begin_test("gap", 3, 2, 2);
    e(0,0,D,0,0,1); e(1,0,D,1,0,0); e(1,1,D,1,0,0); e(1,2,100,1,0,0);
    e(0,0,101,1,0,1); e(0,0,102,1,0,1);
    e(1,0,D,1,0,1); e(1,1,D,1,0,1); e(1,2,100,1,0,1);
    e(0,0,101,1,0,2); e(0,0,102,1,0,2); e(0,0,D,1,1,2); e(0,0,D,0,0,2);
    start = 1'b1; tick(); start = 1'b0;
    drain();

    // Back-to-back frames
    begin_test("b2b", 2, 3, 0);
    e(0,0,D,0,0,2); e(1,0,D,1,0,0); e(1,1,D,1,0,0); e(1,0,100,1,0,1); e(1,1,101,1,0,1);
    e(1,0,100,1,0,2); e(1,1,101,1,0,2); e(0,0,100,1,0,3); e(0,0,101,1,0,3);
    e(0,0,D,1,1,3); e(0,0,D,0,0,3);
    start = 1'b1; tick(); start = 1'b0;
    drain();

    // Infinite loop, abort at cycle 20
    begin_test("inf_abort", 8, 0, 0);
    e(0,0,D,0,0,3);
    for (int k = 1; k <= 20; k++)
      e(1, (k-1) % 8, (k < 3) ? D : 32'(100 + (k-3) % 8), 1, 0, (k <= 8) ? 0 : (k <= 16) ? 1 : 2);
    e(0,0,102,1,1,2); e(0,0,103,0,0,2); e(0,0,D,0,0,2);
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    drain();

    // Zero-length frame: finish without any read
    begin_test("len0", 0, 1, 0);
    e(0,0,D,0,0,2); e(0,0,D,1,1,0); e(0,0,D,0,0,0);
    start = 1'b1; tick(); start = 1'b0;
    drain();

    // Starts while busy are ignored and the config stays latched
    begin_test("start_busy", 4, 1, 0);
    e(0,0,D,0,0,0); e(1,0,D,1,0,0); e(1,1,D,1,0,0); e(1,2,100,1,0,0); e(1,3,101,1,0,0);
    e(0,0,102,1,0,1); e(0,0,103,1,0,1); e(0,0,D,1,1,1); e(0,0,D,0,0,1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); start = 1'b1; frame_len = 12'd2; n_repeats = 16'd5; tick(); start = 1'b0;
    tick(); tick(); start = 1'b1; tick(); start = 1'b0; frame_len = 12'd4; n_repeats = 16'd1;
    drain();

    // Abort wins over start in IDLE; abort alone in IDLE does nothing
    begin_test("idle_abort", 4, 1, 0);
    e(0,0,D,0,0,1); e(0,0,D,0,0,1); e(0,0,D,0,0,1); e(0,0,D,0,0,1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0;
    tick(); abort = 1'b0;
    drain();

    // Reset mid-PLAY
    begin_test("rst_mid", 8, 0, 0);
    e(0,0,D,0,0,1); e(1,0,D,1,0,0); e(1,1,D,1,0,0); e(1,2,100,1,0,0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_addr", 64'(bram_addr), 64'd0);
    chk("midrst_en",   64'(bram_en),   64'd0);
    chk("midrst_dac",  64'(dac_val),   64'd0);
    chk("midrst_busy", 64'(busy),      64'd0);
    chk("midrst_rep",  64'(rep_cnt),   64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_nofin%0d", i), 64'(finish), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("postrst_dac",  64'(dac_val), 64'(D));
    chk("postrst_busy", 64'(busy),    64'd0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
